mul_share_arb: RTL and testbench
================================

Name: mul_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one mul_tc_16_16 instance (16x16 signed, combinational, 32-bit product) between two requesters.
- Each requester has a valid/ready operand channel and a valid/ready result channel.
- Operands are registered before the multiplier. The product is registered into a per-channel result buffer.
- Sits between client datapaths and the Booth-Wallace multiplier core.

Parameters:
- RR_INIT, 1'b1: value of the last-granted pointer at reset. 1 means requester 0 wins the first tie.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 operands valid
- req0_ready  output  1  requester 0 operands accepted this cycle
- req0_a  input  16  requester 0 multiplicand, two's complement
- req0_b  input  16  requester 0 multiplier, two's complement
- rsp0_valid  output  1  requester 0 product valid
- rsp0_ready  input  1  requester 0 consumes product
- rsp0_product  output  32  requester 0 signed product
- req1_valid, req1_ready, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_product: same as channel 0, for requester 1
- busy  output  1  operand stage holds an in-flight operation

Behaviour:
- Reset (async, rst=1) clears everything immediately:
  - rsp0_valid=0, rsp1_valid=0, rsp0_product=0, rsp1_product=0, busy=0.
  - Both channel states go to IDLE; the last-granted pointer loads RR_INIT.
  - Any in-flight operation or unread result is discarded; nothing is delivered after reset release.
- Per-channel FSM (ch = 0, 1):
  - IDLE -> INFLIGHT on an operand handshake (reqX_valid && reqX_ready at a clock edge).
  - INFLIGHT -> DONE at the next edge: the product is written to the result buffer and rspX_valid rises.
  - DONE -> IDLE on rspX_valid && rspX_ready at an edge.
  - rspX_product is held stable while rspX_valid=1.
- Eligibility: channel X is eligible iff its state is IDLE and reqX_valid=1.
- Grant (combinational):
  - Only one eligible channel: it is granted.
  - Both eligible: grant the channel that was not the last granted.
  - reqX_ready = grant X. At most one ready is high per cycle.
  - The pointer updates on every grant.
  - Requesters must not make valid depend on ready.
- Operand stage, registered at the grant edge: s_valid=1, s_ch=X, s_a=reqX_a, s_b=reqX_b.
  - mul_tc_16_16 is driven from s_a/s_b.
  - At the next edge the product is stored into rsp[s_ch]_product; s_valid clears unless a new grant happens at that same edge.
  - busy = s_valid.
- Latency: handshake at edge N -> rspX_valid=1 after edge N+1 (one cycle of multiply).
- Throughput:
  - One grant per cycle overall.
  - Each channel has at most one outstanding op, so a channel reissues no sooner than the cycle after its response handshake.
  - Back-to-back grants alternate between channels.
- No combinational path from rspX_ready to reqX_ready. A channel in DONE is not eligible even if rspX_ready=1 that cycle.
- Arithmetic: the full 32-bit signed product, no truncation or saturation.
  - 0x8000*0x8000 = 0x40000000.
- Simultaneous events: in the same cycle, ch0 may complete INFLIGHT->DONE while ch1 is granted; both take effect.
- Reset asserted mid-operation: the result is lost and the FSMs go to IDLE. The first post-reset tie is resolved by RR_INIT.

Test Plan:
- Single op: ch0 sends a=0x6080, b=0x8001, rsp0_ready=1 -> req0_ready=1 in that cycle; rsp0_valid=1 one cycle after the handshake edge with product 0xCFC06080; rsp1_valid stays 0.
- Tie / round-robin: from reset (RR_INIT=1), both valid with ch0 (0xFFFF, 0xFFFF) and ch1 (0x0003, 0xFFFE), both rsp_ready=1:
  - ch0 is granted first -> rsp0 = 0x00000001.
  - ch1 is granted the next cycle -> rsp1 = 0xFFFFFFFA.
  - The next tie goes to ch0.
- Backpressure: ch1 computes 0x7FFF*0x8000 with rsp1_ready=0 for 5 cycles ->
  - rsp1_valid=1 and product 0xC0008000 held stable;
  - req1_ready=0 throughout, while ch0 ops still complete;
  - raising rsp1_ready releases the result and ch1 is eligible the following cycle.
- Corner values: ch0 sends 0x8000*0x8000 -> 0x40000000; ch0 sends 0x0000*0x8001 -> 0x00000000.
- Reset mid-op: assert rst the cycle after a ch0 grant -> rsp0_valid=0 immediately, busy=0, no product delivered after release.
- Random: 1000 random operand pairs on both channels with random valid/ready, compared against $signed(a)*$signed(b) in arrival order per channel -> zero mismatches, no lost or duplicated results.

Source files
------------

// File: rtl/mul_share_arb.sv
// Round-robin front end that lets two requesters share one 16x16 signed multiplier.
// Operands are registered ahead of the multiplier; products land in per-channel result buffers.

package mul_share_arb_pkg;
   localparam int unsigned OP_W   = 16;
   localparam int unsigned PROD_W = 32;
   localparam int unsigned N_CH   = 2;

   typedef struct packed {
      logic [OP_W-1:0] a;
      logic [OP_W-1:0] b;
   } operands_t;

   typedef enum logic [1:0] {
      CH_IDLE     = 2'd0,
      CH_INFLIGHT = 2'd1,
      CH_DONE     = 2'd2
   } ch_state_t;
endpackage

module mul_tc_16_16
   import mul_share_arb_pkg::*;
(
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic [PROD_W-1:0] product
);
   localparam int unsigned N_PP = OP_W / 2;

   logic [OP_W:0]     b_ext;
   logic [PROD_W-1:0] a_ext;
   logic [PROD_W-1:0] pp_raw;
   logic [PROD_W-1:0] pp [N_PP];
   logic [PROD_W-1:0] sum_v, carry_v, sum_n, carry_n;

   // Radix-4 Booth recoding: one partial product per overlapping triplet of b.
   always_comb begin
      b_ext  = {b, 1'b0};
      a_ext  = PROD_W'($signed(a));
      pp_raw = '0;
      for (int unsigned i = 0; i < N_PP; i++) begin
         unique case (b_ext[2*i +: 3])
            3'b001, 3'b010: pp_raw = a_ext;
            3'b011:         pp_raw = a_ext << 1;
            3'b100:         pp_raw = -(a_ext << 1);
            3'b101, 3'b110: pp_raw = -a_ext;
            default:        pp_raw = '0;
         endcase
         pp[i] = pp_raw << (2*i);
      end
   end

   // Carry-save accumulation of the partial products, one final carry-propagate add.
   always_comb begin
      sum_v   = '0;
      carry_v = '0;
      sum_n   = '0;
      carry_n = '0;
      for (int unsigned i = 0; i < N_PP; i++) begin
         sum_n   = sum_v ^ carry_v ^ pp[i];
         carry_n = ((sum_v & carry_v) | (sum_v & pp[i]) | (carry_v & pp[i])) << 1;
         sum_v   = sum_n;
         carry_v = carry_n;
      end
      product = sum_v + carry_v;
   end
endmodule

module mul_share_arb
   import mul_share_arb_pkg::*;
#(
   parameter logic RR_INIT = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OP_W-1:0]   req0_a,
   input  logic [OP_W-1:0]   req0_b,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [PROD_W-1:0] rsp0_product,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OP_W-1:0]   req1_a,
   input  logic [OP_W-1:0]   req1_b,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [PROD_W-1:0] rsp1_product,
   output logic              busy
);
   logic [N_CH-1:0]              req_valid, rsp_ready, elig, grant;
   operands_t                    req_op [N_CH];
   ch_state_t                    st_q [N_CH];
   ch_state_t                    st_d [N_CH];
   logic [N_CH-1:0]              rsp_valid_q, rsp_valid_d;
   logic [N_CH-1:0][PROD_W-1:0]  rsp_prod_q, rsp_prod_d;
   logic                         last_q, last_d;
   logic                         s_valid_q, s_valid_d;
   logic                         s_ch_q, s_ch_d;
   operands_t                    s_op_q, s_op_d;
   logic [PROD_W-1:0]            mul_p;

   mul_tc_16_16 u_mul (
      .a       (s_op_q.a),
      .b       (s_op_q.b),
      .product (mul_p)
   );

   // Eligibility and round-robin grant; last_q names the channel granted most recently.
   always_comb begin
      req_valid = {req1_valid, req0_valid};
      rsp_ready = {rsp1_ready, rsp0_ready};
      req_op[0] = {req0_a, req0_b};
      req_op[1] = {req1_a, req1_b};
      elig      = '0;
      grant     = '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
         elig[c] = (st_q[c] == CH_IDLE) && req_valid[c];
      end
      grant[0] = elig[0] && (!elig[1] || last_q);
      grant[1] = elig[1] && (!elig[0] || !last_q);
   end

   // Next-state for operand stage, result buffers and per-channel FSMs.
   always_comb begin
      last_d      = last_q;
      s_valid_d   = |grant;
      s_ch_d      = s_ch_q;
      s_op_d      = s_op_q;
      rsp_valid_d = rsp_valid_q;
      rsp_prod_d  = rsp_prod_q;
      for (int unsigned c = 0; c < N_CH; c++) begin
         st_d[c] = st_q[c];
      end

      if (|grant) begin
         last_d = grant[1];
         s_ch_d = grant[1];
         s_op_d = grant[1] ? req_op[1] : req_op[0];
      end

      if (s_valid_q) begin
         rsp_prod_d[s_ch_q] = mul_p;
      end

      for (int unsigned c = 0; c < N_CH; c++) begin
         unique case (st_q[c])
            CH_IDLE: begin
               if (grant[c]) st_d[c] = CH_INFLIGHT;
            end
            CH_INFLIGHT: begin
               st_d[c]        = CH_DONE;
               rsp_valid_d[c] = 1'b1;
            end
            CH_DONE: begin
               if (rsp_ready[c]) begin
                  st_d[c]        = CH_IDLE;
                  rsp_valid_d[c] = 1'b0;
               end
            end
            default: begin
               st_d[c]        = CH_IDLE;
               rsp_valid_d[c] = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned c = 0; c < N_CH; c++) begin
            st_q[c] <= CH_IDLE;
         end
         rsp_valid_q <= '0;
         rsp_prod_q  <= '0;
         last_q      <= RR_INIT;
         s_valid_q   <= 1'b0;
         s_ch_q      <= 1'b0;
         s_op_q      <= '0;
      end else begin
         for (int unsigned c = 0; c < N_CH; c++) begin
            st_q[c] <= st_d[c];
         end
         rsp_valid_q <= rsp_valid_d;
         rsp_prod_q  <= rsp_prod_d;
         last_q      <= last_d;
         s_valid_q   <= s_valid_d;
         s_ch_q      <= s_ch_d;
         s_op_q      <= s_op_d;
      end
   end

   assign req0_ready   = grant[0];
   assign req1_ready   = grant[1];
   assign rsp0_valid   = rsp_valid_q[0];
   assign rsp1_valid   = rsp_valid_q[1];
   assign rsp0_product = rsp_prod_q[0];
   assign rsp1_product = rsp_prod_q[1];
   assign busy         = s_valid_q;
endmodule

// File: tb/tb_mul_share_arb.sv
// Scoreboarded bench for mul_share_arb: directed scenarios plus randomized traffic on both channels.

module tb_mul_share_arb;
   localparam logic RR_INIT = 1'b1;
   localparam int   N_RAND  = 1000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
   logic [31:0] rsp0_product, rsp1_product;
   logic        busy;

   always #5 clk = ~clk;

   mul_share_arb #(.RR_INIT(RR_INIT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_product(rsp0_product),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_product(rsp1_product),
      .busy(busy)
   );

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q0 [$];
   logic [31:0] exp_q1 [$];
   int          pops [2] = '{0, 0};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic get_v(input int c);
      return (c == 0) ? req0_valid : req1_valid;
   endfunction
   function automatic logic get_ready(input int c);
      return (c == 0) ? req0_ready : req1_ready;
   endfunction
   function automatic logic get_rv(input int c);
      return (c == 0) ? rsp0_valid : rsp1_valid;
   endfunction
   function automatic logic get_rr(input int c);
      return (c == 0) ? rsp0_ready : rsp1_ready;
   endfunction
   function automatic logic [31:0] get_rp(input int c);
      return (c == 0) ? rsp0_product : rsp1_product;
   endfunction

   function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
      int p;
      p = int'($signed(a)) * int'($signed(b));
      return 32'(p);
   endfunction

   task automatic set_ch(input int c, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic r);
      if (c == 0) begin
         req0_valid = v; req0_a = a; req0_b = b; rsp0_ready = r;
      end else begin
         req1_valid = v; req1_a = a; req1_b = b; rsp1_ready = r;
      end
   endtask

   // Reference model: one outstanding op per channel, the not-last-granted channel wins ties.
   logic m_out [2];
   int   m_age [2];
   logic m_last;
   logic m_e [2];
   logic m_g [2];
   logic m_rv [2];
   logic m_busy;

   always begin
      @(negedge clk);
      #1;
      if (rst) begin
         exp_q0.delete();
         exp_q1.delete();
         m_out[0] = 1'b0; m_out[1] = 1'b0;
         m_age[0] = 0;    m_age[1] = 0;
         m_last   = RR_INIT;
      end else begin
         m_busy = 1'b0;
         for (int c = 0; c < 2; c++) begin
            if (m_out[c]) m_age[c]++;
            m_rv[c] = m_out[c] && (m_age[c] >= 2);
            m_e[c]  = !m_out[c] && get_v(c);
            if (m_out[c] && m_age[c] == 1) m_busy = 1'b1;
         end
         if (m_e[0] && m_e[1]) begin
            m_g[0] = (m_last == 1'b1);
            m_g[1] = !m_g[0];
         end else begin
            m_g[0] = m_e[0];
            m_g[1] = m_e[1];
         end
         chk("req0_ready", 32'(req0_ready), 32'(m_g[0]));
         chk("req1_ready", 32'(req1_ready), 32'(m_g[1]));
         chk("rsp0_valid", 32'(rsp0_valid), 32'(m_rv[0]));
         chk("rsp1_valid", 32'(rsp1_valid), 32'(m_rv[1]));
         chk("busy", 32'(busy), 32'(m_busy));
         for (int c = 0; c < 2; c++) begin
            if (m_rv[c] && get_rr(c)) m_out[c] = 1'b0;
            if (m_g[c]) begin
               if (c == 0) exp_q0.push_back(ref_prod(req0_a, req0_b));
               else        exp_q1.push_back(ref_prod(req1_a, req1_b));
               m_out[c]  = 1'b1;
               m_age[c]  = 0;
               m_last    = 1'(c);
            end
         end
      end
   end

   // Monitor: compares every presented product against the head of its channel's queue.
   logic [31:0] mon_exp;
   always begin
      @(negedge clk);
      #2;
      if (!rst) begin
         for (int c = 0; c < 2; c++) begin
            if (get_rv(c)) begin
               if ((c == 0 && exp_q0.size() == 0) || (c == 1 && exp_q1.size() == 0)) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_rsp ch=%0d actual=%h expected=none", c, get_rp(c));
               end else begin
                  mon_exp = (c == 0) ? exp_q0[0] : exp_q1[0];
                  chk((c == 0) ? "rsp0_product" : "rsp1_product", get_rp(c), mon_exp);
                  if (get_rr(c)) begin
                     if (c == 0) void'(exp_q0.pop_front());
                     else        void'(exp_q1.pop_front());
                     pops[c]++;
                  end
               end
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      set_ch(0, 1'b0, '0, '0, 1'b1);
      set_ch(1, 1'b0, '0, '0, 1'b1);
      #1;
      chk("rst_rsp0_valid", 32'(rsp0_valid), 0);
      chk("rst_rsp1_valid", 32'(rsp1_valid), 0);
      chk("rst_rsp0_product", rsp0_product, 0);
      chk("rst_rsp1_product", rsp1_product, 0);
      chk("rst_busy", 32'(busy), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic single(input int c, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp_p, input string nm);
      @(negedge clk);
      set_ch(c, 1'b1, a, b, 1'b1);
      #1 chk({nm, "_ready"}, 32'(get_ready(c)), 1);
      @(negedge clk);
      set_ch(c, 1'b0, a, b, 1'b1);
      @(negedge clk);
      #1;
      chk({nm, "_valid"}, 32'(get_rv(c)), 1);
      chk({nm, "_prod"}, get_rp(c), exp_p);
      chk({nm, "_other_idle"}, 32'(get_rv(1 - c)), 0);
      @(negedge clk);
   endtask

   function automatic logic [15:0] rand_op();
      case ($urandom_range(7, 0))
         0:       return 16'h8000;
         1:       return 16'h7FFF;
         2:       return 16'hFFFF;
         3:       return 16'h0000;
         default: return 16'($urandom);
      endcase
   endfunction

   int          sent [2];
   logic        took [2];
   logic        rv [2];
   logic [15:0] ra [2];
   logic [15:0] rb [2];
   int          bp_before;

   initial begin
      do_reset();

      single(0, 16'h6080, 16'h8001, 32'hCFC06080, "single");

      // Tie from reset: ch0 first, then ch1, then the next tie returns to ch0.
      do_reset();
      @(negedge clk);
      set_ch(0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
      set_ch(1, 1'b1, 16'h0003, 16'hFFFE, 1'b1);
      #1;
      chk("tie_first_ch0", 32'(req0_ready), 1);
      chk("tie_first_not_ch1", 32'(req1_ready), 0);
      @(negedge clk);
      set_ch(0, 1'b0, 16'h0, 16'h0, 1'b1);
      #1 chk("tie_second_ch1", 32'(req1_ready), 1);
      @(negedge clk);
      set_ch(1, 1'b0, 16'h0, 16'h0, 1'b1);
      #1;
      chk("tie_rsp0_valid", 32'(rsp0_valid), 1);
      chk("tie_rsp0_prod", rsp0_product, 32'h00000001);
      @(negedge clk);
      #1;
      chk("tie_rsp1_valid", 32'(rsp1_valid), 1);
      chk("tie_rsp1_prod", rsp1_product, 32'hFFFFFFFA);
      @(negedge clk);
      set_ch(0, 1'b1, 16'h0002, 16'h0003, 1'b1);
      set_ch(1, 1'b1, 16'hFFF9, 16'h0005, 1'b1);
      #1 chk("tie_next_ch0", 32'(req0_ready), 1);
      @(negedge clk);
      set_ch(0, 1'b0, 16'h0, 16'h0, 1'b1);
      @(negedge clk);
      set_ch(1, 1'b0, 16'h0, 16'h0, 1'b1);
      repeat (4) @(negedge clk);

      // Backpressure on ch1 while ch0 keeps completing.
      set_ch(1, 1'b1, 16'h7FFF, 16'h8000, 1'b0);
      #1 chk("bp_grant", 32'(req1_ready), 1);
      @(negedge clk);
      set_ch(1, 1'b1, 16'h0002, 16'h0003, 1'b0);
      @(negedge clk);
      bp_before = pops[0];
      for (int i = 0; i < 5; i++) begin
         set_ch(0, 1'b1, 16'(16'h0010 + i), 16'h0020, 1'b1);
         #1;
         chk("bp_rsp1_valid", 32'(rsp1_valid), 1);
         chk("bp_rsp1_prod", rsp1_product, 32'hC0008000);
         chk("bp_req1_blocked", 32'(req1_ready), 0);
         @(negedge clk);
      end
      chk("bp_ch0_progress", 32'(pops[0] > bp_before), 1);
      set_ch(0, 1'b0, 16'h0, 16'h0, 1'b1);
      set_ch(1, 1'b1, 16'h0002, 16'h0003, 1'b1);
      #1 chk("bp_done_not_eligible", 32'(req1_ready), 0);
      @(negedge clk);
      #1 chk("bp_reissue", 32'(req1_ready), 1);
      @(negedge clk);
      set_ch(1, 1'b0, 16'h0, 16'h0, 1'b1);
      repeat (4) @(negedge clk);

      single(0, 16'h8000, 16'h8000, 32'h40000000, "corner_min");
      single(0, 16'h0000, 16'h8001, 32'h00000000, "corner_zero");
      single(1, 16'h7FFF, 16'h7FFF, 32'h3FFF0001, "corner_max1");

      // Reset while ch0 is in flight: result discarded, nothing delivered later.
      @(negedge clk);
      set_ch(0, 1'b1, 16'h1234, 16'h5678, 1'b1);
      #1 chk("rstmid_grant", 32'(req0_ready), 1);
      @(negedge clk);
      set_ch(0, 1'b0, 16'h0, 16'h0, 1'b1);
      rst = 1'b1;
      #1;
      chk("rstmid_rsp0_valid", 32'(rsp0_valid), 0);
      chk("rstmid_busy", 32'(busy), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      #1 chk("rstmid_no_delivery", 32'(rsp0_valid), 0);

      // Randomized traffic on both channels.
      for (int c = 0; c < 2; c++) begin
         sent[c] = 0; took[c] = 1'b0; rv[c] = 1'b0; ra[c] = '0; rb[c] = '0;
      end
      for (int n = 0; n < 20000 && (sent[0] < N_RAND || sent[1] < N_RAND); n++) begin
         @(negedge clk);
         for (int c = 0; c < 2; c++) begin
            if (!rv[c] || took[c]) begin
               if (sent[c] < N_RAND && $urandom_range(3, 0) != 0) begin
                  rv[c] = 1'b1;
                  ra[c] = rand_op();
                  rb[c] = rand_op();
               end else begin
                  rv[c] = 1'b0;
               end
            end
            set_ch(c, rv[c], ra[c], rb[c], $urandom_range(2, 0) != 0);
         end
         #1;
         for (int c = 0; c < 2; c++) begin
            took[c] = rv[c] && get_ready(c);
            if (took[c]) sent[c]++;
         end
      end
      chk("rand_sent_ch0", 32'(sent[0]), 32'(N_RAND));
      chk("rand_sent_ch1", 32'(sent[1]), 32'(N_RAND));

      @(negedge clk);
      set_ch(0, 1'b0, '0, '0, 1'b1);
      set_ch(1, 1'b0, '0, '0, 1'b1);
      for (int n = 0; n < 20 && (exp_q0.size() + exp_q1.size()) != 0; n++) begin
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
      chk("drain_empty", 32'(exp_q0.size() + exp_q1.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
